// File: rtl/axi_pc_status_logger.sv
// axi_pc_status_logger: captures first/sticky protocol-checker violations, counts new events, serves them over a word read port
module axi_pc_status_logger #(
  parameter int STATUS_W = 160,
  parameter int CNT_W = 32,
  parameter int TS_W = 48
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [STATUS_W-1:0] pc_status,
  input  logic                pc_asserted,
  input  logic                clear,
  input  logic                irq_en,
  output logic                irq,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [4:0]          rd_addr,
  output logic                rd_data_valid,
  output logic [31:0]         rd_data,
  input  logic                rd_data_ready
);
  localparam int NW = STATUS_W / 32;
  typedef enum logic {IDLE, CAPTURED} cap_t;
  typedef enum logic {R_IDLE, R_RESP} rd_t;
  cap_t cap_state, cap_next;
  rd_t rd_state, rd_next;
  logic [TS_W-1:0] ts, first_ts;
  logic [STATUS_W-1:0] sticky, first_status;
  logic [CNT_W-1:0] count;
  logic ovf, captured, evt, trig, accept;
  logic [31:0] rd_word;
  assign captured = cap_state == CAPTURED;
  assign evt = |(pc_status & ~sticky);
  assign trig = pc_asserted | (|pc_status);
  assign rd_ready = rd_state == R_IDLE;
  assign rd_data_valid = rd_state == R_RESP;
  assign accept = rd_valid & rd_ready;
  always_comb begin
    cap_next = clear ? IDLE : (!captured && trig) ? CAPTURED : cap_state;
    rd_next = accept ? R_RESP : (rd_data_valid && rd_data_ready) ? R_IDLE : rd_state;
  end
  always_comb begin
    rd_word = rd_addr == 5'd16 ? 32'(count) :
              rd_addr == 5'd17 ? first_ts[31:0] :
              rd_addr == 5'd18 ? 32'(first_ts >> 32) :
              rd_addr == 5'd19 ? {30'b0, ovf, captured} :
              rd_addr == 5'd20 ? ts[31:0] : 32'b0;
    for (int i = 0; i < NW; i++) begin
      if (rd_addr == 5'(i)) rd_word = first_status[32*i +: 32];
      if (rd_addr == 5'(8 + i)) rd_word = sticky[32*i +: 32];
    end
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      cap_state <= IDLE;
      rd_state <= R_IDLE;
      ts <= '0;
      first_ts <= '0;
      first_status <= '0;
      sticky <= '0;
      count <= '0;
      ovf <= 1'b0;
      irq <= 1'b0;
      rd_data <= '0;
    end else begin
      cap_state <= cap_next;
      rd_state <= rd_next;
      ts <= ts + 1'b1;
      irq <= captured & irq_en;
      if (accept) rd_data <= rd_word;
      if (clear) begin
        first_ts <= '0;
        first_status <= '0;
        sticky <= '0;
        count <= '0;
        ovf <= 1'b0;
      end else begin
        if (evt) begin
          sticky <= sticky | pc_status;
          count <= &count ? count : count + 1'b1;
          ovf <= ovf | (&count);
        end
        if (!captured && trig) begin
          first_status <= pc_status;
          first_ts <= ts;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_pc_status_logger.sv
// tb_axi_pc_status_logger: directed vectors checked against a per-cycle behavioural model plus literal read expectations
module tb_axi_pc_status_logger;
  localparam int SW = 160;
  localparam int NW = SW / 32;
  localparam int CMAX = 3;
  logic clk, areset, pc_asserted, clear, irq_en, irq;
  logic rd_valid, rd_ready, rd_data_valid, rd_data_ready;
  logic [SW-1:0] pc_status;
  logic [4:0] rd_addr;
  logic [31:0] rd_data;
  int n_pass = 0;
  int n_total = 0;
  logic [SW-1:0] m_sticky = '0, m_first = '0;
  logic [47:0] m_ts = '0, m_first_ts = '0;
  int m_count = 0;
  logic m_ovf = 0, m_cap = 0, m_irq = 0, m_rresp = 0;
  logic [31:0] m_rdata = '0;
  axi_pc_status_logger #(.STATUS_W(SW), .CNT_W(2), .TS_W(48)) dut (
    .aclk(clk), .areset(areset), .pc_status(pc_status), .pc_asserted(pc_asserted),
    .clear(clear), .irq_en(irq_en), .irq(irq), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_ready(rd_data_ready)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [31:0] mword(input int a);
    if (a < NW) return m_first[32*a +: 32];
    if (a >= 8 && a < 8 + NW) return m_sticky[32*(a-8) +: 32];
    case (a)
      16: return 32'(m_count);
      17: return m_first_ts[31:0];
      18: return {16'b0, m_first_ts[47:32]};
      19: return {30'b0, m_ovf, m_cap};
      20: return m_ts[31:0];
      default: return 32'b0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (areset) begin
      m_sticky = '0;
      m_first = '0;
      m_ts = '0;
      m_first_ts = '0;
      m_count = 0;
      m_ovf = 0;
      m_cap = 0;
      m_irq = 0;
      m_rresp = 0;
      m_rdata = '0;
    end else begin
      if (!m_rresp && rd_valid) begin
        m_rresp = 1;
        m_rdata = mword(int'(rd_addr));
      end else if (m_rresp && rd_data_ready) m_rresp = 0;
      m_irq = m_cap && irq_en;
      if (clear) begin
        m_sticky = '0;
        m_first = '0;
        m_first_ts = '0;
        m_count = 0;
        m_ovf = 0;
        m_cap = 0;
      end else begin
        if ((pc_status & ~m_sticky) != '0) begin
          m_sticky = m_sticky | pc_status;
          if (m_count == CMAX) m_ovf = 1;
          else m_count++;
        end
        if (!m_cap && (pc_asserted || pc_status != '0)) begin
          m_cap = 1;
          m_first = pc_status;
          m_first_ts = m_ts;
        end
      end
      m_ts++;
    end
  end
  always @(negedge clk) begin
    chk("irq", irq, m_irq);
    chk("rd_ready", rd_ready, !m_rresp);
    chk("rd_data_valid", rd_data_valid, m_rresp);
    chk("rd_data", rd_data, m_rdata);
  end
  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    int i = 0;
    while (!rd_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_rdy"}, rd_ready, 1);
    rd_valid = 1;
    rd_addr = a;
    @(negedge clk);
    rd_valid = 0;
    chk({nm, "_v"}, rd_data_valid, 1);
    chk(nm, rd_data, exp);
    rd_data_ready = 1;
    @(negedge clk);
    rd_data_ready = 0;
  endtask
  initial begin
    areset = 1;
    pc_status = '0;
    pc_asserted = 0;
    clear = 0;
    irq_en = 0;
    rd_valid = 0;
    rd_addr = '0;
    rd_data_ready = 0;
    repeat (3) @(negedge clk);
    areset = 0;
    chk("irq_rst", irq, 0);
    chk("rd_ready_rst", rd_ready, 1);
    rd(19, 0, "status_rst");
    irq_en = 1;
    for (int i = 0; i < 200 && m_ts != 48'd100; i++) @(negedge clk);
    pc_status[5] = 1;
    pc_asserted = 1;
    repeat (2) @(negedge clk);
    pc_status[70] = 1;
    @(negedge clk);
    rd(0, 32'h20, "first_w0");
    rd(2, 32'h0, "first_w2");
    rd(17, 32'd100, "first_ts_lo");
    rd(18, 32'd0, "first_ts_hi");
    rd(8, 32'h20, "sticky_w0");
    rd(10, 32'h40, "sticky_w2");
    rd(16, 32'd2, "count_2");
    rd(19, 32'h1, "status_cap");
    chk("irq_set", irq, 1);
    pc_status[100] = 1;
    @(negedge clk);
    rd(16, 32'd3, "count_3");
    rd(19, 32'h1, "status_no_ovf");
    pc_status[150] = 1;
    @(negedge clk);
    rd(16, 32'd3, "count_sat");
    rd(19, 32'h3, "status_ovf");
    pc_status[120] = 1;
    clear = 1;
    @(negedge clk);
    clear = 0;
    rd_valid = 1;
    rd_addr = 16;
    @(negedge clk);
    rd_valid = 0;
    chk("clr_count", rd_data, 0);
    chk("clr_irq", irq, 0);
    rd_data_ready = 1;
    @(negedge clk);
    rd_data_ready = 0;
    rd(16, 32'd1, "recap_count");
    rd(19, 32'h1, "recap_status");
    rd(0, 32'h20, "recap_w0");
    rd_valid = 1;
    rd_addr = 16;
    @(negedge clk);
    rd_valid = 0;
    pc_status[30] = 1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", rd_data, 1);
      chk("stall_rdy", rd_ready, 0);
      chk("stall_v", rd_data_valid, 1);
      @(negedge clk);
    end
    rd_data_ready = 1;
    chk("stall_done", rd_data, 1);
    @(negedge clk);
    rd_data_ready = 0;
    chk("stall_drop", rd_data_valid, 0);
    rd(16, 32'd2, "count_after_stall");
    rd(0, 32'h20, "first_frozen");
    rd_valid = 1;
    rd_addr = 16;
    @(negedge clk);
    rd_valid = 0;
    chk("abort_pre_v", rd_data_valid, 1);
    areset = 1;
    pc_status = '0;
    pc_asserted = 0;
    @(negedge clk);
    chk("abort_v", rd_data_valid, 0);
    chk("abort_data", rd_data, 0);
    areset = 0;
    rd(0, 0, "rst_first");
    rd(8, 0, "rst_sticky");
    rd(16, 0, "rst_count");
    rd(17, 0, "rst_ts");
    rd(19, 0, "rst_status");
    pc_asserted = 1;
    @(negedge clk);
    pc_asserted = 0;
    rd(19, 32'h1, "asserted_cap");
    rd(16, 32'd0, "asserted_no_evt");
    rd(0, 32'h0, "asserted_w0");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
